// File: rtl/uart_tx_if.sv
// Producer-side handshake and status bundle for the uart_tx serialiser.
// The producer drives tx_start/tx_byte; the transmitter drives ready and frame status.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_active;
  logic       tx_done;

  modport master (output tx_start, tx_byte, input tx_ready, tx_active, tx_done);
  modport slave  (input tx_start, tx_byte, output tx_ready, tx_active, tx_done);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding buffer and registered serial output.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1, sense set by PARITY_ODD).
module uart_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int PARITY_ODD   = 0
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx,
  output logic     RsTx
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx: CLKS_PER_BIT must be 4..65535 and PARITY_ODD 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_SENSE = 1'(PARITY_ODD);
`endif

  state_t      state, state_nxt;
  logic [15:0] bit_cnt, cnt_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  hold_byte, hold_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic        rs_tx, rs_nxt;
  logic        active, active_nxt;
  logic        done, done_nxt;
  logic        bit_end;
  logic        accept;

  assign bit_end = (bit_cnt == LAST_CNT);
  assign accept  = tx.tx_start && !hold_valid;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = bit_cnt;
    idx_nxt        = bit_idx;
    shift_nxt      = shift;
    hold_nxt       = hold_byte;
    hold_valid_nxt = hold_valid;
    rs_nxt         = 1'b1;
    active_nxt     = 1'b0;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (hold_valid) begin
          shift_nxt      = hold_byte;
          hold_valid_nxt = 1'b0;
          state_nxt      = START;
        end
      end
      START: begin
        rs_nxt     = 1'b0;
        active_nxt = 1'b1;
        if (bit_end) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cnt_nxt = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        rs_nxt     = shift[bit_idx];
        active_nxt = 1'b1;
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = bit_cnt + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        rs_nxt     = (^shift) ^ PARITY_SENSE;
        active_nxt = 1'b1;
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
        end else begin
          cnt_nxt = bit_cnt + 16'd1;
        end
      end
`endif
      STOP: begin
        active_nxt = 1'b1;
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = CLEANUP;
        end else begin
          cnt_nxt = bit_cnt + 16'd1;
        end
      end
      CLEANUP: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    // A refill on the same edge as the IDLE hand-off must win over the clear.
    if (accept) begin
      hold_nxt       = tx.tx_byte;
      hold_valid_nxt = 1'b1;
    end
  end

  // NOTE: the data registers (shift, hold_byte) are reset too; they are only
  // eight bits each and a known value keeps the line idle-safe after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      hold_byte  <= '0;
      hold_valid <= 1'b0;
      rs_tx      <= 1'b1;
      active     <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      bit_cnt    <= cnt_nxt;
      bit_idx    <= idx_nxt;
      shift      <= shift_nxt;
      hold_byte  <= hold_nxt;
      hold_valid <= hold_valid_nxt;
      rs_tx      <= rs_nxt;
      active     <= active_nxt;
      done       <= done_nxt;
    end
  end

  // Outputs are registered from the current state, so the line trails state by one clock.
  assign RsTx         = rs_tx;
  assign tx.tx_ready  = !hold_valid;
  assign tx.tx_active = active;
  assign tx.tx_done   = done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed bytes feed a scoreboard queue and an
// RX loopback monitor decodes RsTx at bit centres and compares against it.
module tb_uart_tx;
  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME   = 176;
  localparam int SPACING = 178;
`else
  localparam int FRAME   = 160;
  localparam int SPACING = 162;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic RsTx;

  uart_tx_if bus();

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk  (clk),
    .rst  (rst),
    .tx   (bus),
    .RsTx (RsTx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t sb_q[$];
  int   fall_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   fall_cnt = 0;
  int   done_cnt = 0;
  int   active_cnt = 0;
  int   last_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon_wait(input int n, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) aborted = 1'b1;
    end
  endtask

  // RX loopback: detect the start edge, sample each bit at its centre, score the byte.
  initial begin : rx_monitor
    logic       prev;
    logic [7:0] got;
    logic       stop_bit;
`ifdef UART_TX_PARITY_EN
    logic       par_bit;
`endif
    bit         ab;
    exp_t       e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !RsTx) begin
        fall_q.push_back(cyc);
        fall_cnt++;
        got      = '0;
        stop_bit = 1'b0;
        mon_wait(CPB / 2, ab);
        if (!ab) check("rx_start_bit", RsTx, 0);
        for (int i = 0; i < 8 && !ab; i++) begin
          mon_wait(CPB, ab);
          got[i] = RsTx;
        end
`ifdef UART_TX_PARITY_EN
        par_bit = 1'b0;
        if (!ab) begin
          mon_wait(CPB, ab);
          par_bit = RsTx;
        end
`endif
        if (!ab) begin
          mon_wait(CPB, ab);
          stop_bit = RsTx;
        end
        if (!ab) begin
          check("rx_frame_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rx_byte", got, e.data);
            check("rx_stop_bit", stop_bit, 1);
`ifdef UART_TX_PARITY_EN
            check("rx_parity_bit", par_bit, e.par);
`endif
          end
        end
      end
      prev = RsTx;
    end
  end

  initial begin : status_monitor
    forever begin
      @(negedge clk);
      if (bus.tx_done) begin
        done_cnt++;
        last_done = cyc;
      end
      if (bus.tx_active) active_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Offer one byte, honouring tx_ready; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] b, input logic par, output int acc_cyc);
    int n;
    exp_t e;
    n = 0;
    acc_cyc = 0;
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) begin
      check("send_ready_timeout", bus.tx_ready, 1);
    end else begin
      bus.tx_start = 1'b1;
      bus.tx_byte  = b;
      @(posedge clk);
      e.data = b;
      e.par  = par;
      sb_q.push_back(e);
      @(negedge clk);
      acc_cyc      = cyc;
      bus.tx_start = 1'b0;
      bus.tx_byte  = 8'($urandom);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", done_cnt >= target, 1);
  endtask

  initial begin : stimulus
    int bad, acc, d0, f0, target;
    bus.tx_start = 1'b0;
    bus.tx_byte  = 8'h00;
    rst = 1'b1;
    bad = 0;

    // Test 1: reset values, then idle line
    repeat (5) begin
      @(negedge clk);
      if (RsTx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_active !== 1'b0 || bus.tx_done !== 1'b0) bad++;
    end
    check("t1_rst_line", RsTx, 1);
    check("t1_rst_ready", bus.tx_ready, 1);
    check("t1_rst_active", bus.tx_active, 0);
    check("t1_rst_done", bus.tx_done, 0);
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (RsTx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_active !== 1'b0 || bus.tx_done !== 1'b0) bad++;
    end
    check("t1_idle_violations", bad, 0);

    // Test 2: single byte 0xA5
    active_cnt = 0;
    d0 = done_cnt;
    f0 = fall_cnt;
    send(8'hA5, 1'b0, acc);
    wait_done(d0 + 1, 400);
    repeat (20) @(negedge clk);
    check("t2_frames", fall_cnt - f0, 1);
    if (fall_cnt > f0) begin
      check("t2_fall_latency", fall_q[$] - acc, 2);
      check("t2_done_offset", last_done - fall_q[$], FRAME);
    end
    check("t2_active_cycles", active_cnt, FRAME);
    check("t2_done_pulses", done_cnt - d0, 1);

    // Test 3: back-to-back 0x00 then 0xFF
    d0 = done_cnt;
    f0 = fall_cnt;
    send(8'h00, 1'b0, acc);
    send(8'hFF, 1'b0, acc);
    wait_done(d0 + 2, 800);
    repeat (20) @(negedge clk);
    check("t3_frames", fall_cnt - f0, 2);
    if (fall_cnt >= f0 + 2) check("t3_start_spacing", fall_q[$] - fall_q[$-1], SPACING);

    // Test 4: tx_start ignored while the holding buffer is full
    d0 = done_cnt;
    f0 = fall_cnt;
    send(8'h81, 1'b0, acc);
    send(8'h3C, 1'b0, acc);
    check("t4_ready_low_when_full", bus.tx_ready, 0);
    bus.tx_start = 1'b1;
    bus.tx_byte  = 8'h99;
    repeat (20) @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_byte  = 8'h00;
    wait_done(d0 + 2, 800);
    repeat (200) @(negedge clk);
    check("t4_frames", fall_cnt - f0, 2);
    check("t4_sb_empty", sb_q.size(), 0);

    // Test 5: reset at data bit 3 of 0x55 with 0xAA buffered
    d0 = done_cnt;
    f0 = fall_cnt;
    send(8'h55, 1'b0, acc);
    send(8'hAA, 1'b0, acc);
    bad = 0;
    while (fall_cnt == f0 && bad < 50) begin
      @(negedge clk);
      bad++;
    end
    check("t5_frame_started", fall_cnt - f0, 1);
    if (fall_cnt > f0) begin
      target = fall_q[$] + CPB / 2 + 4 * CPB;
      while (cyc < target) @(negedge clk);
    end
    check("t5_line_bit3", RsTx, 0);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("t5_rst_line_high", RsTx, 1);
    check("t5_rst_ready", bus.tx_ready, 1);
    check("t5_rst_active", bus.tx_active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_no_new_frame", fall_cnt - f0, 1);

`ifdef UART_TX_PARITY_EN
    // Test 6: even parity, 0x07 -> 1 and 0x03 -> 0
    d0 = done_cnt;
    f0 = fall_cnt;
    send(8'h07, 1'b1, acc);
    wait_done(d0 + 1, 400);
    if (fall_cnt > f0) check("t6_frame_len_07", last_done - fall_q[$], 176);
    send(8'h03, 1'b0, acc);
    wait_done(d0 + 2, 400);
    repeat (20) @(negedge clk);
    check("t6_frames", fall_cnt - f0, 2);
    if (fall_cnt >= f0 + 2) check("t6_frame_len_03", last_done - fall_q[$], 176);
`endif

    repeat (50) @(negedge clk);
    check("final_sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
